stream_packer: RTL and testbench

//   Downstream neighbour of the single-stage valid/ready pipeline register.

---
 rtl/stream_packer.sv | 108 ++++++++++
 tb/tb_stream_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Purpose: packs RATIO consecutive WIDTH-bit beats into one WIDTH*RATIO-bit word with a lane keep mask; in_last flushes a partial word.
// Latency: out_valid rises the cycle after the completing beat is accepted; one input beat per cycle, also while a word drains.
// Backpressure: in_ready = ~out_valid | out_ready; a held word keeps out_* stable and stalls the input.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid/in_ready     narrow input handshake; in_data beat, in_last ends packet
//   out_valid/out_ready   packed output handshake
//   out_data              lane k = bits [k*WIDTH +: WIDTH]; unfilled lanes read 0
//   out_keep              bit k set => lane k holds a real beat (contiguous from bit 0)
//   out_last              word ends a packet
module stream_packer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {ASSEMBLE = 1'b0, FULL = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;   // next lane to fill while assembling; 0 while FULL
  logic          in_fire;
  logic          last_lane;

  // Ready depends only on our own registered valid and the consumer's ready,
  // so there is no combinational path from in_valid back to in_ready.
  assign in_ready  = ~out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign last_lane = (cnt == CW'(RATIO - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ASSEMBLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ASSEMBLE: begin
          if (in_fire) begin
            // Constant-index lane write keeps the part-select widths static.
            for (int k = 0; k < RATIO; k++) begin
              if (cnt == CW'(k)) begin
                out_data[k*WIDTH +: WIDTH] <= in_data;
                out_keep[k]                <= 1'b1;
              end
            end
            if (last_lane || in_last) begin
              state     <= FULL;
              out_valid <= 1'b1;
              out_last  <= in_last;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              // Old word drains while the new beat lands in lane 0, so the
              // stream keeps one beat per cycle across word boundaries.
              out_data <= {{(WIDTH*(RATIO-1)){1'b0}}, in_data};
              out_keep <= {{(RATIO-1){1'b0}}, 1'b1};
              if (in_last) begin
                out_last <= 1'b1;
              end else begin
                state     <= ASSEMBLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                cnt       <= CW'(1);
              end
            end else begin
              state     <= ASSEMBLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_keep  <= '0;
              out_last  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= ASSEMBLE;
          out_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Purpose: self-checking bench for stream_packer (WIDTH=32, RATIO=4) with a scoreboard of expected words.
// Latency: expected words are pushed when their completing beat fires and popped when the DUT fires a word.
// Backpressure: exercised by holding out_ready low against a full word.
module tb_stream_packer;

  localparam int WIDTH = 32;
  localparam int RATIO = 4;

  logic                   clk;
  logic                   rstn;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   out_valid;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]       out_keep;
  logic                   out_last;
  logic                   out_ready;

  stream_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH*RATIO-1:0] d;
    logic [RATIO-1:0]       k;
    logic                   l;
  } word_t;

  word_t sbq[$];

  int n_cmp;
  int n_err;
  int words_out;
  int stall_cnt;

  // reference assembly state
  logic [WIDTH*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  int                     m_cnt;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: inputs are stable between posedge+1 and the next posedge, so the
  // handshakes seen at negedge are the ones that fire at the coming edge.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
      m_data = '0;
      m_keep = '0;
      m_cnt  = 0;
    end else begin
      if (in_valid && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        words_out++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_word", 1, 0);
        end else begin
          word_t e;
          e = sbq.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_keep", out_keep, e.k);
          chk("sb_last", out_last, e.l);
        end
      end
      if (in_valid && in_ready) begin
        m_data[m_cnt*WIDTH +: WIDTH] = in_data;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == RATIO-1 || in_last) begin
          word_t w;
          w.d = m_data;
          w.k = m_keep;
          w.l = in_last;
          sbq.push_back(w);
          m_data = '0;
          m_keep = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic put(input logic [WIDTH-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("put_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; words_out = 0; stall_cnt = 0;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_keep",  out_keep, 0);
    chk("rst_out_last",  out_last, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    step();

    // 1: full word with last on the fourth beat
    put(32'hAAAA0001, 0); put(32'hBBBB0002, 0); put(32'hCCCC0003, 0); put(32'hDDDD0004, 1);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    chk("t1_keep",  out_keep, 4'b1111);
    chk("t1_last",  out_last, 1);
    step();

    // 2: early flush after two beats
    put(32'h11, 0); put(32'h22, 1);
    @(negedge clk);
    chk("t2_valid", out_valid, 1);
    chk("t2_data",  out_data, 128'h0_0_00000022_00000011);
    chk("t2_keep",  out_keep, 4'b0011);
    chk("t2_last",  out_last, 1);
    step();

    // 3: hold a full word for 5 cycles with beat E pending
    out_ready = 1'b0;
    put(32'h30000001, 0); put(32'h30000002, 0); put(32'h30000003, 0); put(32'h30000004, 0);
    in_valid = 1'b1; in_data = 32'hEEEE0005; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_hold_valid",   out_valid, 1);
      chk("t3_hold_data",    out_data, 128'h30000004_30000003_30000002_30000001);
      chk("t3_hold_keep",    out_keep, 4'b1111);
      chk("t3_hold_last",    out_last, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_e_accepted", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid_after_overlap", out_valid, 0);
    step();
    put(32'hF0000006, 0); put(32'hF0000007, 0); put(32'hF0000008, 0);
    @(negedge clk);
    chk("t4_lane0_is_e", out_data, 128'hF0000008_F0000007_F0000006_EEEE0005);
    chk("t4_keep", out_keep, 4'b1111);
    step();

    // 4b: overlapping drain with a last beat
    put(32'h41, 0); put(32'h42, 0); put(32'h43, 0); put(32'h44, 0);
    put(32'hE2E2E2E2, 1);
    @(negedge clk);
    chk("t4b_valid", out_valid, 1);
    chk("t4b_data",  out_data, 128'h0_0_0_E2E2E2E2);
    chk("t4b_keep",  out_keep, 4'b0001);
    chk("t4b_last",  out_last, 1);
    step();

    // 5: stream 12 beats back to back
    begin
      int w0, s0;
      w0 = words_out;
      s0 = stall_cnt;
      for (int i = 0; i < 12; i++) put(32'h50000000 + i, (i == 11));
      repeat (2) @(negedge clk);
      chk("t5_words", words_out - w0, 3);
      chk("t5_no_stall", stall_cnt - s0, 0);
      step();
    end

    // 6: reset after two beats discards the partial word
    put(32'hA1, 0); put(32'hA2, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data",  out_data, 0);
    chk("t6_rst_keep",  out_keep, 0);
    chk("t6_rst_last",  out_last, 0);
    step();
    rstn = 1'b1;
    step();
    put(32'h61, 0); put(32'h62, 0); put(32'h63, 0); put(32'h64, 0);
    @(negedge clk);
    chk("t6_data", out_data, 128'h00000064_00000063_00000062_00000061);
    chk("t6_keep", out_keep, 4'b1111);
    chk("t6_last", out_last, 0);
    step();

    repeat (3) @(negedge clk);
    chk("total_words", words_out, 10);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
